tm1638_frame_ctrl: RTL

Frame controller that pushes the three-digit BCD result (`dec_out[11:0]`) to a TM1638 display/LED driver over its 3-wire serial bus. On each `start` request it latches the digits and maps them to 7-segment codes. It then sequences one complete TM1638 refresh frame: data command, address plus 16 display bytes, and display control. It sits between the BCD converter and the board pins, and is the only master of the TM1638 bus.

---
 rtl/tm1638_frame_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/tm1638_frame_ctrl.sv
// TM1638 frame controller: latches three BCD digits on start and shifts one full
// refresh frame (data cmd, address + 16 display bytes, display control) out LSB first.
module tm1638_frame_ctrl #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [2:0]  BRIGHT  = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] dec_out,
    output logic        busy,
    output logic        done,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio
);

    localparam int unsigned CW = $clog2(2 * CLK_DIV + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStbSetup,
        StBitLow,
        StBitHigh,
        StStbGap
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [4:0]    byte_q, byte_d;
    logic [1:0]    txn_q, txn_d;
    logic [11:0]   dec_q, dec_d;
    logic          stb_q, stb_d, clk_q, clk_d, dio_q, dio_d, busy_q, busy_d, done_q, done_d;
    logic [4:0]    last_byte;
    logic [7:0]    tx_byte;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h40;
        endcase
    endfunction

    assign last_byte = (txn_q == 2'd1) ? 5'd16 : 5'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        txn_d   = txn_q;
        dec_d   = dec_q;
        stb_d   = stb_q;
        clk_d   = clk_q;
        dio_d   = dio_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tx_byte = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StStbSetup;
                    dec_d   = dec_out;
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    txn_d   = '0;
                    stb_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStbSetup: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = StBitLow;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBitLow: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = StBitHigh;
                    cnt_d   = '0;
                    clk_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBitHigh: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (byte_q == last_byte) begin
                            // Release STB while CLK is still high.
                            state_d = StStbGap;
                            byte_d  = '0;
                            stb_d   = 1'b1;
                        end else begin
                            state_d = StBitLow;
                            byte_d  = byte_q + 5'd1;
                            clk_d   = 1'b0;
                        end
                    end else begin
                        state_d = StBitLow;
                        bit_d   = bit_q + 3'd1;
                        clk_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStbGap: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (txn_q == 2'd2) begin
                        state_d = StIdle;
                        txn_d   = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StStbSetup;
                        txn_d   = txn_q + 2'd1;
                        stb_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Byte on the wire is selected by the counters the FSM is moving to.
        case (txn_d)
            2'd0: tx_byte = 8'h40;
            2'd1: begin
                case (byte_d)
                    5'd0:    tx_byte = 8'hC0;
                    5'd1:    tx_byte = seg7(dec_q[11:8]);
                    5'd3:    tx_byte = seg7(dec_q[7:4]);
                    5'd5:    tx_byte = seg7(dec_q[3:0]);
                    default: tx_byte = 8'h00;
                endcase
            end
            default: tx_byte = 8'h88 | {5'b00000, BRIGHT};
        endcase

        if (state_d == StBitLow && state_q != StBitLow) begin
            dio_d = tx_byte[bit_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            txn_q   <= '0;
            dec_q   <= '0;
            stb_q   <= 1'b1;
            clk_q   <= 1'b1;
            dio_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            txn_q   <= txn_d;
            dec_q   <= dec_d;
            stb_q   <= stb_d;
            clk_q   <= clk_d;
            dio_q   <= dio_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign tm_stb = stb_q;
    assign tm_clk = clk_q;
    assign tm_dio = dio_q;

endmodule
